// File: rtl/raster_scan_ctrl_if.sv
// raster_scan_ctrl_if: pixel stream handshake and window-centre report.
// master is the upstream/consumer side; slave is the controller.
interface raster_scan_ctrl_if #(parameter int CNT_W = 10);
    logic             in_valid;
    logic             in_ready;
    logic             win_valid;
    logic [CNT_W-1:0] win_cx;
    logic [CNT_W-1:0] win_cy;
    modport master (output in_valid, input in_ready, win_valid, win_cx, win_cy);
    modport slave (input in_valid, output in_ready, win_valid, win_cx, win_cy);
endinterface

// File: rtl/raster_scan_ctrl.sv
// raster_scan_ctrl: walks a raster over a run-time sized frame, one pixel per
// beat, and reports the centre of each FAST window as it becomes complete.
module raster_scan_ctrl #(
    parameter int CNT_W  = 10,
    parameter int RADIUS = 3
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_height,
    raster_scan_ctrl_if.slave pix,
    output logic             busy,
    output logic             frame_done,
    output logic             cfg_err
);
    localparam logic [CNT_W-1:0] WIN  = CNT_W'(2 * RADIUS + 1);
    localparam logic [CNT_W-1:0] SPAN = CNT_W'(2 * RADIUS);
    localparam logic [CNT_W-1:0] R    = CNT_W'(RADIUS);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] width_q, height_q, col, row, col_d, row_d;
    logic             col_flag, row_flag, beat, last, clr, cfg_ok, accept, win_hit;

    assign pix.in_ready = state == SCAN;
    assign busy         = state == SCAN;
    assign frame_done   = state == DONE;

    always_comb begin
        beat    = pix.in_valid && state == SCAN;
        cfg_ok  = cfg_width >= WIN && cfg_height >= WIN;
        accept  = state == IDLE && start && !abort && cfg_ok;
        last    = beat && col_flag && row_flag;
        clr     = state != SCAN || abort || last;
        win_hit = beat && col >= SPAN && row >= SPAN;
        col_d   = clr ? '0 : beat ? (col_flag ? '0 : col + 1'b1) : col;
        row_d   = clr ? '0 : (beat && col_flag) ? (row_flag ? '0 : row + 1'b1) : row;
        state_d = abort ? IDLE :
                  state == IDLE ? (accept ? SCAN : IDLE) :
                  state == SCAN ? (last ? DONE : SCAN) : IDLE;
    end

    // Flags are registered from the next count so they track count == rollover_val.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state         <= IDLE;
            width_q       <= '0;
            height_q      <= '0;
            col           <= '0;
            row           <= '0;
            col_flag      <= 1'b0;
            row_flag      <= 1'b0;
            cfg_err       <= 1'b0;
            pix.win_valid <= 1'b0;
            pix.win_cx    <= '0;
            pix.win_cy    <= '0;
        end else begin
            state    <= state_d;
            col      <= col_d;
            row      <= row_d;
            col_flag <= !clr && col_d == width_q - 1'b1;
            row_flag <= !clr && row_d == height_q - 1'b1;
            cfg_err  <= state == IDLE && start && !abort && !cfg_ok;
            if (accept) begin
                width_q  <= cfg_width;
                height_q <= cfg_height;
            end
            pix.win_valid <= win_hit;
            if (win_hit) begin
                pix.win_cx <= col - R;
                pix.win_cy <= row - R;
            end
        end
    end
endmodule

// File: tb/tb_raster_scan_ctrl.sv
// tb_raster_scan_ctrl: table of frame vectors plus directed sequences for
// cfg rejection, abort and mid-frame reset.
module tb_raster_scan_ctrl;
    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [9:0] cfg_width = '0;
    logic [9:0] cfg_height = '0;
    logic       busy, frame_done, cfg_err;
    int         checks = 0;
    int         errors = 0;

    raster_scan_ctrl_if #(.CNT_W(10)) pix ();

    raster_scan_ctrl #(.CNT_W(10), .RADIUS(3)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .pix(pix),
        .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w; int h; bit stall;
        int nwin; int busy_cyc; int fcx; int fcy; int lcx; int lcy;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_in_ready"}, int'(pix.in_ready), 0);
        chk({tag, "_win_valid"}, int'(pix.win_valid), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    task automatic start_frame(input int w, input int h);
        cfg_width = 10'(w);
        cfg_height = 10'(h);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", int'(busy), 1);
        chk("start_in_ready", int'(pix.in_ready), 1);
    endtask

    task automatic beats(input int n);
        pix.in_valid = 1'b1;
        repeat (n) @(negedge clk);
        pix.in_valid = 1'b0;
    endtask

    // Runs one frame with an independent coordinate model; win/done timing checked every cycle.
    task automatic run_frame(input int w, input int h, input bit stall,
                             output int nwin, output int busy_cyc,
                             output int fcx, output int fcy, output int lcx, output int lcy);
        int x = 0, y = 0, pcx = 0, pcy = 0;
        bit pend = 0, exp_done = 0, ph = 1, seen = 0;
        nwin = 0; busy_cyc = 0; fcx = -1; fcy = -1; lcx = -1; lcy = -1;
        start_frame(w, h);
        for (int cyc = 0; cyc < 20000; cyc++) begin
            chk("win_valid", int'(pix.win_valid), int'(pend));
            if (pend) begin
                chk("win_cx", int'(pix.win_cx), pcx);
                chk("win_cy", int'(pix.win_cy), pcy);
            end
            if (pix.win_valid) begin
                if (nwin == 0) begin fcx = int'(pix.win_cx); fcy = int'(pix.win_cy); end
                lcx = int'(pix.win_cx); lcy = int'(pix.win_cy);
                nwin++;
            end
            chk("frame_done", int'(frame_done), int'(exp_done));
            chk("in_ready", int'(pix.in_ready), int'(!exp_done));
            if (busy) busy_cyc++;
            if (exp_done) begin seen = 1; break; end
            pix.in_valid = stall ? ph : 1'b1;
            ph = !ph;
            pend = pix.in_valid && x >= 6 && y >= 6;
            pcx = x - 3;
            pcy = y - 3;
            if (pix.in_valid) begin
                exp_done = x == w - 1 && y == h - 1;
                if (x == w - 1) begin x = 0; y++; end else x++;
            end
            @(negedge clk);
        end
        pix.in_valid = 1'b0;
        if (!seen) chk("frame_timeout", 0, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_ignored", int'(busy), 0);
    endtask

    task automatic check_vec(input int i, input string tag);
        int nwin, bc, fcx, fcy, lcx, lcy;
        run_frame(vecs[i].w, vecs[i].h, vecs[i].stall, nwin, bc, fcx, fcy, lcx, lcy);
        chk({tag, "_nwin"}, nwin, vecs[i].nwin);
        chk({tag, "_busy_cycles"}, bc, vecs[i].busy_cyc);
        chk({tag, "_first_cx"}, fcx, vecs[i].fcx);
        chk({tag, "_first_cy"}, fcy, vecs[i].fcy);
        chk({tag, "_last_cx"}, lcx, vecs[i].lcx);
        chk({tag, "_last_cy"}, lcy, vecs[i].lcy);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{w: 7,  h: 7,  stall: 0, nwin: 1,  busy_cyc: 49,  fcx: 3, fcy: 3, lcx: 3, lcy: 3};
        vecs[1] = '{w: 9,  h: 8,  stall: 0, nwin: 6,  busy_cyc: 72,  fcx: 3, fcy: 3, lcx: 5, lcy: 4};
        vecs[2] = '{w: 7,  h: 7,  stall: 1, nwin: 1,  busy_cyc: 97,  fcx: 3, fcy: 3, lcx: 3, lcy: 3};
        vecs[3] = '{w: 10, h: 10, stall: 0, nwin: 16, busy_cyc: 100, fcx: 3, fcy: 3, lcx: 6, lcy: 6};
        vecs[4] = '{w: 8,  h: 7,  stall: 1, nwin: 2,  busy_cyc: 111, fcx: 3, fcy: 3, lcx: 4, lcy: 3};
        pix.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle_zero("reset");
        chk("reset_win_cx", int'(pix.win_cx), 0);
        chk("reset_win_cy", int'(pix.win_cy), 0);
        chk("reset_cfg_err", int'(cfg_err), 0);
        n_rst = 1'b1;
        @(negedge clk);

        // Undersized configurations are rejected with a single cfg_err strobe.
        cfg_width = 10'd6; cfg_height = 10'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("cfg_err_w6", int'(cfg_err), 1);
        chk("cfg_err_w6_busy", int'(busy), 0);
        @(negedge clk);
        chk("cfg_err_w6_clear", int'(cfg_err), 0);
        chk("cfg_err_w6_busy2", int'(busy), 0);
        cfg_width = 10'd10; cfg_height = 10'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("cfg_err_h6", int'(cfg_err), 1);
        chk("cfg_err_h6_busy", int'(busy), 0);
        @(negedge clk);

        for (int i = 0; i < 5; i++) check_vec(i, $sformatf("vec%0d", i));

        // Abort on beat 20 of a 10x10 frame, then a clean frame.
        start_frame(10, 10);
        beats(19);
        pix.in_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        pix.in_valid = 1'b0; abort = 1'b0;
        chk_idle_zero("abort20");
        @(negedge clk);
        chk("abort20_no_done", int'(frame_done), 0);
        check_vec(3, "post_abort");

        // Abort on the last beat: window still reported, no frame_done.
        start_frame(7, 7);
        beats(48);
        pix.in_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        pix.in_valid = 1'b0; abort = 1'b0;
        chk("abort_last_win_valid", int'(pix.win_valid), 1);
        chk("abort_last_cx", int'(pix.win_cx), 3);
        chk("abort_last_cy", int'(pix.win_cy), 3);
        chk("abort_last_done", int'(frame_done), 0);
        chk("abort_last_busy", int'(busy), 0);
        @(negedge clk);
        chk("abort_last_done2", int'(frame_done), 0);
        chk("abort_last_win2", int'(pix.win_valid), 0);

        // Reset on the last beat drops the pending window.
        start_frame(7, 7);
        beats(48);
        pix.in_valid = 1'b1; n_rst = 1'b0;
        @(negedge clk);
        pix.in_valid = 1'b0; n_rst = 1'b1;
        chk_idle_zero("midrst");
        chk("midrst_win_cx", int'(pix.win_cx), 0);
        chk("midrst_win_cy", int'(pix.win_cy), 0);
        chk("midrst_cfg_err", int'(cfg_err), 0);
        @(negedge clk);
        check_vec(0, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
